dmem_rr_arbiter: RTL and testbench
==================================

# dmem_rr_arbiter

Round-robin arbiter that shares the single data-memory port among the eight ARM cores of the multi-core MCU. It replaces the OR-ed write-enable and per-core address fan-in with one serialized command stream: exactly one access per cycle, with per-core grant and read-return handshakes. It sits between the `arm` instances and `dmem`, and its memory-side command outputs are registered.

## Interface
Parameters:
- `N_REQ`, 8, number of requesting cores (2..16)
- `AW`, 32, address width
- `DW`, 32, data width

Ports (name, direction, width, meaning):
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `req`  in  N_REQ  per-core access request; held high with `we`/`addr`/`wdata` stable until granted
- `we`  in  N_REQ  per-core write flag (1 = store, 0 = load)
- `addr`  in  N_REQ*AW  per-core address, core i at `[i*AW +: AW]`
- `wdata`  in  N_REQ*DW  per-core store data, same packing
- `lock`  in  N_REQ  per-core bus-lock request; present only with `DMEM_ARB_LOCK_EN`
- `gnt`  out  N_REQ  one-hot combinational grant; the request is accepted this cycle
- `rvalid`  out  N_REQ  one-hot load-return strobe
- `rdata`  out  DW  load return data, shared by all cores, qualified by `rvalid`
- `mem_en`  out  1  registered memory command valid
- `mem_we`  out  1  registered memory write enable
- `mem_addr`  out  AW  registered memory address
- `mem_wdata`  out  DW  registered memory write data
- `mem_rdata`  in  DW  memory read data, valid one cycle after a read command
- `busy`  out  1  high while any command or load return is in flight

## Operation
- Priority pointer `ptr` (0..N_REQ-1). The winner is the first requester with `req` set, searching upward from `ptr` with wrap-around.
- `gnt` is combinational from `req` and the registered state. At most one bit is high, and no bit is high when `req == 0`.
- On a grant to core i:
  - Next cycle: `mem_en=1`, and `mem_we`, `mem_addr` and `mem_wdata` come from core i's sampled inputs.
  - `ptr <= (i+1) mod N_REQ`.
- Load tracking:
  - Registered tag `rd_tag`, and `rd_pend` set when a read command issues.
  - The cycle after a read command issues, `rvalid[rd_tag]=1` and `rdata=mem_rdata`.
  - Stores produce no `rvalid`.
- Requester rules:
  - A core must not drop `req` before `gnt`.
  - After `gnt` it may immediately present a new request the next cycle.
- Cycles with no request: `mem_en=0`, and `mem_we`/`mem_addr`/`mem_wdata` are driven 0.
- Reset values: `ptr=0`, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `rd_pend=0`, `rvalid=0`, `rdata=0`, `busy=0`, lock owner none.
- Reset mid-operation: any in-flight command and pending `rvalid` are discarded and are not returned after reset releases.
- Width rules:
  - Pointer is `$clog2(N_REQ)` bits.
  - Wrap from `N_REQ-1` to 0 is explicit; the pointer does not rely on power-of-two overflow.

## Timing
- Request to grant: 0 cycles when the bus is free and the core wins; otherwise bounded by `N_REQ-1` grants to other cores.
- Grant to memory command: 1 cycle.
- Load grant to `rvalid`: 2 cycles.
- Throughput: one access per cycle, back-to-back, with no bubble between different cores.
- Simultaneous requests from all N_REQ cores are serviced in N_REQ consecutive cycles, in order `ptr`, `ptr+1`, and so on.
- A store and a load from different cores in consecutive cycles: the store is written before the load is issued, giving read-after-write ordering in grant order.
- `busy = mem_en | rd_pend`.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - When core i is granted with `lock[i]=1`, it becomes lock owner.
  - While owned, only the owner can be granted; other requests stall.
  - Ownership is released on the first grant to the owner with `lock[i]=0`, or when `req[i]=0 && lock[i]=0`.
  - On release, `ptr` resumes at owner+1.
- Undefined:
  - The `lock` port is absent and the lock-owner register is not built.
  - Behaviour is pure round-robin.

## Structure
- Package `dmem_arb_pkg` holds:
  - `N_REQ_DEF=8`
  - `AW_DEF`/`DW_DEF=32`
  - `req_idx_t` (index typedef)
  - `mem_cmd_t` struct {en, we, addr, wdata}
- One sub-module, `rr_picker`: a purely combinational one-hot round-robin select from `req` and `ptr`. It is reused by any later shared peripheral bus.

## Test plan
- Single core 3 store, `addr=0x40`, `wdata=0x1234`:
  - `gnt[3]` in the same cycle.
  - Next cycle: `mem_en=1`, `mem_we=1`, `mem_addr=0x40`.
  - No `rvalid`.
- All 8 `req` high from reset, loads: grants 0,1,…,7 in 8 consecutive cycles, each followed 2 cycles later by the matching `rvalid[i]` with the `mem_rdata` of its address.
- Core 7 granted, then cores 0 and 7 request together: `gnt[0]` first (ptr=0), then `gnt[7]`.
- Core 2 store `0xAA` to `0x80`, then core 5 load `0x80` in the next cycle: `rvalid[5]` with `rdata=0xAA`.
- Assert `reset` the cycle after a load grant: `rvalid` stays 0, all memory outputs are 0, and `ptr=0` after release.
- With `DMEM_ARB_LOCK_EN`, core 4 holds `lock=1` for 3 requests while core 1 requests:
  - Grants go 4, 4, 4.
  - Core 4 then drops `lock` and core 1 is granted the next cycle.

Source files
------------

// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared types and default sizes for the data-memory round-robin arbiter.
package dmem_arb_pkg;

    localparam int N_REQ_DEF = 8;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int IDX_W_DEF = $clog2(N_REQ_DEF);

    typedef logic [IDX_W_DEF-1:0] req_idx_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/dmem_rr_arbiter_rr_picker.sv
// Combinational one-hot round-robin select: first set request at or above ptr, wrapping.
// Kept generic so other shared peripheral buses can reuse it.
module rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Scan N candidates starting at ptr; the wrap is an explicit subtraction so N need not be a power of two
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int            c;
            logic [PW-1:0] w_cand;
            c = int'(i_ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            w_cand = c[PW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter serialising per-core data-memory accesses onto one registered port.
// Optional bus locking is built when DMEM_ARB_LOCK_EN is defined.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [N_REQ-1:0]    lock,
`endif
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                busy
);

    localparam int            PW   = $clog2(N_REQ);
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_cmd_tag;
    logic [PW-1:0]    r_rd_tag;
    logic             r_rd_pend;
    logic             r_mem_en;
    logic             r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_idx;
    logic             w_any;

`ifdef DMEM_ARB_LOCK_EN
    logic          r_lock_own;
    logic [PW-1:0] r_lock_idx;
    logic          w_lock_hold;

    assign w_lock_hold = r_lock_own && (req[r_lock_idx] || lock[r_lock_idx]);

    // While a core owns the bus only its request is visible to the picker
    always_comb begin
        w_elig = req;
        if (w_lock_hold) begin
            w_elig             = '0;
            w_elig[r_lock_idx] = req[r_lock_idx];
        end
    end

    // Take ownership on a locked grant; drop it on an unlocked grant or once the owner goes fully idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_own <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_any) begin
            r_lock_own <= lock[w_idx];
            r_lock_idx <= w_idx;
        end else if (r_lock_own && !w_lock_hold) begin
            r_lock_own <= 1'b0;
        end
    end
`else
    assign w_elig = req;
`endif

    rr_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_picker (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign gnt = w_gnt;

    // Register the winner's command and advance the priority pointer past it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cmd_tag   <= '0;
        end else if (w_any) begin
            r_ptr       <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= we[w_idx];
            r_mem_addr  <= addr[w_idx*AW +: AW];
            r_mem_wdata <= wdata[w_idx*DW +: DW];
            r_cmd_tag   <= w_idx;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end
    end

    // Remember which core owns the read that memory answers next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_tag  <= '0;
        end else begin
            r_rd_pend <= r_mem_en && !r_mem_we;
            r_rd_tag  <= r_cmd_tag;
        end
    end

    // Steer the returning read data to its owner as a one-hot strobe
    always_comb begin
        rvalid = '0;
        if (r_rd_pend) begin
            rvalid[r_rd_tag] = 1'b1;
        end
    end

    assign rdata     = r_rd_pend ? mem_rdata : '0;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_mem_en | r_rd_pend;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Scoreboard bench for dmem_rr_arbiter: directed vectors push expected grants, commands and
// load returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_rr_arbiter;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [2:0]    idx;
        logic [DW-1:0] data;
    } rv_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N-1:0]    lockSig = '0;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;

    logic [AW-1:0]   coreAddr  [N];
    logic [DW-1:0]   coreWdata [N];
    logic [DW-1:0]   memArr [logic [AW-1:0]];

    logic [N-1:0]    gntQ [$];
    cmd_t            cmdQ [$];
    rv_t             rvQ  [$];

    int              total = 0;
    int              bad = 0;

    logic [N-1:0]    monGnt;
    cmd_t            monCmd;
    rv_t             monRv;

    dmem_rr_arbiter #(
        .N_REQ (N),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef DMEM_ARB_LOCK_EN
        .lock      (lockSig),
`endif
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pack the per-core address and store data vectors
    always_comb begin
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = coreAddr[i];
            wdata[i*DW +: DW] = coreWdata[i];
        end
    end

    // Data memory: unwritten words read back as D000 followed by the low address half
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                memArr[mem_addr] = mem_wdata;
            end else if (memArr.exists(mem_addr)) begin
                mem_rdata <= memArr[mem_addr];
            end else begin
                mem_rdata <= {16'hD000, mem_addr[15:0]};
            end
        end
    end

    task automatic checkVal(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented grant, command and load return is matched against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (gntQ.size() > 0) begin
                monGnt = gntQ.pop_front();
                checkVal("gnt", 96'(gnt), 96'(monGnt));
            end else if (gnt != '0) begin
                checkVal("gnt unexpected", 96'(gnt), 96'(0));
            end
            if (mem_en) begin
                checkVal("busy with cmd", 96'(busy), 96'(1));
                if (cmdQ.size() > 0) begin
                    monCmd = cmdQ.pop_front();
                    checkVal("mem cmd", 96'({mem_we, mem_addr, mem_wdata}), 96'(monCmd));
                end else begin
                    checkVal("mem_en unexpected", 96'(mem_en), 96'(0));
                end
            end
            if (rvalid != '0) begin
                if (rvQ.size() > 0) begin
                    monRv = rvQ.pop_front();
                    checkVal("rvalid", 96'(rvalid), 96'(8'b1 << monRv.idx));
                    checkVal("rdata", 96'(rdata), 96'(monRv.data));
                end else begin
                    checkVal("rvalid unexpected", 96'(rvalid), 96'(0));
                end
            end
        end
    end

    // Drive one cycle of requests and queue the responses it should produce
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] lk,
                                 input logic [N-1:0] expGnt, input logic [DW-1:0] expRd, input bit track);
        logic [2:0] gi;
        cmd_t       c;
        rv_t        v;
        req     = r;
        we      = w;
        lockSig = lk;
        gi      = '0;
        for (int i = 0; i < N; i++) begin
            if (expGnt[i]) gi = 3'(i);
        end
        gntQ.push_back(expGnt);
        if (track && expGnt != '0) begin
            c.we    = w[gi];
            c.addr  = coreAddr[gi];
            c.wdata = coreWdata[gi];
            cmdQ.push_back(c);
            if (!w[gi]) begin
                v.idx  = gi;
                v.data = expRd;
                rvQ.push_back(v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " mem_en"}, 96'(mem_en), 96'(0));
        checkVal({tag, " mem_we"}, 96'(mem_we), 96'(0));
        checkVal({tag, " mem_addr"}, 96'(mem_addr), 96'(0));
        checkVal({tag, " mem_wdata"}, 96'(mem_wdata), 96'(0));
        checkVal({tag, " rvalid"}, 96'(rvalid), 96'(0));
        checkVal({tag, " rdata"}, 96'(rdata), 96'(0));
        checkVal({tag, " busy"}, 96'(busy), 96'(0));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, '0, '0, '0, '0, 1'b0);
        end
        checkOutput("idle");
    endtask

    task automatic doReset();
        req   = '0;
        we    = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            coreAddr[i]  = '0;
            coreWdata[i] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        reset = 1'b0;

        // Single core 3 store
        coreAddr[3]  = 32'h40;
        coreWdata[3] = 32'h1234;
        applyStimulus(8'h08, 8'h08, 8'h00, 8'h08, '0, 1'b1);
        idleCycles(3);

        // All cores load together from reset: granted 0..7 back to back
        doReset();
        for (int i = 0; i < N; i++) begin
            coreAddr[i] = 32'h100 + 32'(4 * i);
        end
        for (int k = 0; k < N; k++) begin
            applyStimulus(8'hFF << k, 8'h00, 8'h00, 8'h01 << k, 32'hD000_0100 + 32'(4 * k), 1'b1);
        end
        idleCycles(3);

        // Core 7 granted, then 0 and 7 together: 0 wins after the pointer wraps
        coreAddr[7] = 32'h200;  coreWdata[7] = 32'h77;
        coreAddr[0] = 32'h204;  coreWdata[0] = 32'h100;
        applyStimulus(8'h80, 8'h80, 8'h00, 8'h80, '0, 1'b1);
        applyStimulus(8'h81, 8'h81, 8'h00, 8'h01, '0, 1'b1);
        applyStimulus(8'h80, 8'h80, 8'h00, 8'h80, '0, 1'b1);
        idleCycles(2);

        // Core 2 stores, core 5 loads the same word next cycle
        coreAddr[2] = 32'h80;  coreWdata[2] = 32'hAA;
        coreAddr[5] = 32'h80;  coreWdata[5] = 32'h0;
        applyStimulus(8'h04, 8'h04, 8'h00, 8'h04, '0, 1'b1);
        applyStimulus(8'h20, 8'h00, 8'h00, 8'h20, 32'hAA, 1'b1);
        idleCycles(3);

        // Reset the cycle after a load grant: nothing returns, pointer back to 0
        coreAddr[6] = 32'h300;
        applyStimulus(8'h40, 8'h00, 8'h00, 8'h40, '0, 1'b0);
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        coreAddr[3] = 32'h40;
        applyStimulus(8'h88, 8'h00, 8'h00, 8'h08, 32'h1234, 1'b1);
        idleCycles(3);

`ifdef DMEM_ARB_LOCK_EN
        // Core 4 holds the lock for three grants while core 1 waits
        coreAddr[4] = 32'h400;  coreWdata[4] = 32'h44;
        coreAddr[1] = 32'h404;  coreWdata[1] = 32'h11;
        applyStimulus(8'h10, 8'h10, 8'h10, 8'h10, '0, 1'b1);
        applyStimulus(8'h12, 8'h12, 8'h10, 8'h10, '0, 1'b1);
        applyStimulus(8'h12, 8'h12, 8'h10, 8'h10, '0, 1'b1);
        applyStimulus(8'h02, 8'h02, 8'h00, 8'h02, '0, 1'b1);
        idleCycles(2);
`endif

        checkVal("gnt queue left", 96'(gntQ.size()), 96'(0));
        checkVal("cmd queue left", 96'(cmdQ.size()), 96'(0));
        checkVal("rvalid queue left", 96'(rvQ.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
